// File: rtl/aho_multi.sv
// aho_multi: free-running event counter with NCH loadable modulo channels and an
// optional BCD digit-match detector, built only when AHO_MULTI_DIGIT_EN is defined.

module aho_multi_ch #(
  parameter int              DIV_W   = 4,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             wrap_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cnt_nz_i,
  output logic             hit_o
);
  logic [DIV_W-1:0] div_q, div_d, res_q, res_d;

  always_comb begin
    div_d = div_q;
    res_d = res_q;
    if (load_i) begin
      div_d = div_i;
      res_d = '0;
    end else if (clr_i) begin
      res_d = '0;
    end else if (en_i) begin
      // a zero divisor parks the residue; the wrap restarts every channel
      if (wrap_i || div_q == '0 || res_q == div_q - 1'b1) res_d = '0;
      else                                             res_d = res_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= DIV_RST;
      res_q <= '0;
    end else begin
      div_q <= div_d;
      res_q <= res_d;
    end
  end

  assign hit_o = (div_q != '0) && (res_q == '0) && cnt_nz_i;
endmodule

module aho_multi #(
  parameter int                    CNT_W     = 16,
  parameter int                    NCH       = 3,
  parameter int                    DIV_W     = 4,
  parameter logic [NCH*DIV_W-1:0]  DIV_INIT  = {4'd7, 4'd5, 4'd3},
  parameter int                    NDIG      = 5,
  parameter int                    MATCH_DIG = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [NCH*DIV_W-1:0] div_i,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [NCH-1:0]       hit_o,
  output logic                 dhit_o,
  output logic                 aho_o,
  output logic                 wrap_o
);
  if (NCH < 1 || NCH > 8 || NDIG < 1 || MATCH_DIG < 0 || MATCH_DIG > 9) begin : g_bad_cfg
    $error("aho_multi: unsupported parameter combination");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max, cnt_nz;

  assign at_max = &cnt_q;
  assign cnt_nz = |cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (load_i || clr_i) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (en_i) begin
      cnt_d  = at_max ? '0 : cnt_q + 1'b1;
      wrap_d = at_max;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    aho_multi_ch #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_INIT[g*DIV_W +: DIV_W])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_i),
      .clr_i   (clr_i),
      .en_i    (en_i),
      .wrap_i  (at_max),
      .div_i   (div_i[g*DIV_W +: DIV_W]),
      .cnt_nz_i(cnt_nz),
      .hit_o   (hit_o[g])
    );
  end

`ifdef AHO_MULTI_DIGIT_EN
  logic [NDIG-1:0][3:0] bcd_q, bcd_d;
  logic                 carry, nonlead, dmatch;

  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    if (load_i || clr_i || (en_i && at_max)) begin
      bcd_d = '0;
    end else if (en_i) begin
      for (int k = 0; k < NDIG; k++) begin
        if (carry) begin
          if (bcd_q[k] == 4'd9) bcd_d[k] = 4'd0;
          else begin
            bcd_d[k] = bcd_q[k] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  // scan from the top digit so leading zeros are excluded from a zero match
  always_comb begin
    nonlead = 1'b0;
    dmatch  = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nonlead = nonlead | (bcd_q[k] != 4'd0);
      if (nonlead && bcd_q[k] == 4'(MATCH_DIG)) dmatch = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bcd_q <= '0;
    else         bcd_q <= bcd_d;
  end

  assign dhit_o = dmatch & cnt_nz;
`else
  assign dhit_o = 1'b0;
`endif

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  assign aho_o  = (|hit_o) | dhit_o;
endmodule

// File: tb/tb_aho_multi.sv
// Scoreboard bench for aho_multi: a 16-bit instance, a 4-bit wrap instance and a
// MATCH_DIG=0 instance share stimulus; expectations come from a modulo/decimal model.
module tb_aho_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, load = 1'b0;
  logic [11:0] div = '0;

  logic [15:0] cnt;  logic [2:0] hit;  logic dh, aho, wr;
  logic [3:0]  scnt; logic [2:0] shit; logic sdh, saho, swr;
  logic [15:0] zcnt; logic [2:0] zhit; logic zdh, zaho, zwr;

  always #5 clk = ~clk;

  aho_multi u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load), .div_i(div),
    .cnt_o(cnt), .hit_o(hit), .dhit_o(dh), .aho_o(aho), .wrap_o(wr));

  aho_multi #(.CNT_W(4), .NDIG(2)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load), .div_i(div),
    .cnt_o(scnt), .hit_o(shit), .dhit_o(sdh), .aho_o(saho), .wrap_o(swr));

  aho_multi #(.MATCH_DIG(0)) u_zero (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load), .div_i(div),
    .cnt_o(zcnt), .hit_o(zhit), .dhit_o(zdh), .aho_o(zaho), .wrap_o(zwr));

  typedef struct {
    logic [15:0] cnt; logic [2:0] hit; logic dh, aho, wr;
    logic [3:0] scnt; logic [2:0] shit; logic sdh, saho, swr;
    logic zdh;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0, nerr = 0;
  int          mn = 0, ms = 0;
  logic        mw = 1'b0, msw = 1'b0;
  logic [3:0]  dv [3];

  function automatic logic dig_hit(int n, int m, int nd);
    int v = n;
    if (n == 0) return 1'b0;
    for (int k = 0; k < nd; k++) begin
      if (v == 0) break;
      if (v % 10 == m) return 1'b1;
      v = v / 10;
    end
    return 1'b0;
  endfunction

  function automatic logic [2:0] hits(int n, logic [3:0] d0, logic [3:0] d1, logic [3:0] d2);
    logic [2:0] h;
    h[0] = (d0 != 0) && (n % int'(d0) == 0) && (n != 0);
    h[1] = (d1 != 0) && (n % int'(d1) == 0) && (n != 0);
    h[2] = (d2 != 0) && (n % int'(d2) == 0) && (n != 0);
    return h;
  endfunction

  function automatic logic dmodel(int n, int m, int nd);
`ifdef AHO_MULTI_DIGIT_EN
    return dig_hit(n, m, nd);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mn = 0; ms = 0; mw = 1'b0; msw = 1'b0;
    dv[0] = 4'd3; dv[1] = 4'd5; dv[2] = 4'd7;
  endtask

  task automatic step(logic e, logic c, logic l, logic [11:0] d);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; load = l; div = d;
    if (l) begin
      for (int i = 0; i < 3; i++) dv[i] = d[i*4 +: 4];
      mn = 0; ms = 0; mw = 1'b0; msw = 1'b0;
    end else if (c) begin
      mn = 0; ms = 0; mw = 1'b0; msw = 1'b0;
    end else if (e) begin
      mw  = (mn == 65535); mn = mw  ? 0 : mn + 1;
      msw = (ms == 15);    ms = msw ? 0 : ms + 1;
    end
    x.cnt  = mn[15:0];
    x.hit  = hits(mn, dv[0], dv[1], dv[2]);
    x.dh   = dmodel(mn, 3, 5);
    x.aho  = (|x.hit) | x.dh;
    x.wr   = mw;
    x.scnt = ms[3:0];
    x.shit = hits(ms, dv[0], dv[1], dv[2]);
    x.sdh  = dmodel(ms, 3, 2);
    x.saho = (|x.shit) | x.sdh;
    x.swr  = msw;
    x.zdh  = dmodel(mn, 0, 5);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk($sformatf("cnt n=%0d", mn),  32'(cnt),  32'(x.cnt));
    chk($sformatf("hit n=%0d", mn),  32'(hit),  32'(x.hit));
    chk($sformatf("dhit n=%0d", mn), 32'(dh),   32'(x.dh));
    chk($sformatf("aho n=%0d", mn),  32'(aho),  32'(x.aho));
    chk($sformatf("wrap n=%0d", mn), 32'(wr),   32'(x.wr));
    chk($sformatf("s.cnt n=%0d", ms),  32'(scnt), 32'(x.scnt));
    chk($sformatf("s.hit n=%0d", ms),  32'(shit), 32'(x.shit));
    chk($sformatf("s.aho n=%0d", ms),  32'(saho), 32'(x.saho));
    chk($sformatf("s.wrap n=%0d", ms), 32'(swr),  32'(x.swr));
    chk($sformatf("z.dhit n=%0d", mn), 32'(zdh),  32'(x.zdh));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " cnt"},  32'(cnt),  0);
    chk({tag, " hit"},  32'(hit),  0);
    chk({tag, " dhit"}, 32'(dh),   0);
    chk({tag, " aho"},  32'(aho),  0);
    chk({tag, " wrap"}, 32'(wr),   0);
    chk({tag, " s.cnt"}, 32'(scnt), 0);
    chk({tag, " s.wrap"}, 32'(swr), 0);
    chk({tag, " z.aho"}, 32'(zaho), 0);
  endtask

  initial begin
    model_reset();
    #3 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // default divisors 3/5/7; small instance wraps at 16
    for (int i = 0; i < 20; i++) step(1, 0, 0, '0);
    // CLR wins over EN at n=20, divisors kept
    step(1, 1, 0, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, '0);
    // LOAD wins over EN at n=9
    step(1, 0, 1, {4'd0, 4'd4, 4'd2});
    for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
    // hold cycles: nothing moves, WRAP/hits keep their values
    step(0, 0, 0, 12'hfff);
    step(0, 0, 0, '0);
    // unaligned DIV ignored without LOAD
    step(1, 0, 0, 12'h111);
    // restore defaults and walk the digit range past 103
    step(0, 0, 1, {4'd7, 4'd5, 4'd3});
    for (int i = 0; i < 105; i++) step(1, 0, 0, '0);
    // async reset mid-count restores the reset divisors
    step(0, 0, 1, {4'd1, 4'd0, 4'd6});
    for (int i = 0; i < 37; i++) step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
